// File: rtl/mips_datapath.sv
// Five-stage pipelined MIPS32 subset core with hazard unit,
// instruction ROM, data RAM and register file.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic    regWrite;
    logic    memtoReg;
    logic    memWrite;
    logic    aluSrc;
    logic    regDst;
    alu_op_e aluOp;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
  } if_id_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] signImm;
  } id_ex_t;

  typedef struct packed {
    logic        regWrite;
    logic        memtoReg;
    logic        memWrite;
    logic [31:0] aluOut;
    logic [31:0] writeData;
    logic [4:0]  writeReg;
  } ex_mem_t;

  typedef struct packed {
    logic        regWrite;
    logic        memtoReg;
    logic [31:0] aluOut;
    logic [31:0] readData;
    logic [4:0]  writeReg;
  } mem_wb_t;

endpackage

module mips_datapath
  import mips_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  output logic [31:0] out [4:0],
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4F,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        BranchD,
  output logic        PCSrcD,
  output logic [31:0] PCBranchD,
  output logic [31:0] SrcAD,
  output logic [31:0] SrcBD
);

  if_id_t  ifId;
  id_ex_t  idEx;
  ex_mem_t exMem;
  mem_wb_t memWb;

  logic [31:0] pcF;
  logic [31:0] instrF;
  logic [31:0] rf [32];
  logic [31:0] dmem [64];

  logic [5:0]  opD;
  logic [5:0]  functD;
  logic [4:0]  rsD;
  logic [4:0]  rtD;
  logic [4:0]  rdD;
  logic [31:0] signImmD;
  logic [31:0] rd1D;
  logic [31:0] rd2D;
  ctrl_t       ctrlD;

  logic [1:0]  fwdAE;
  logic [1:0]  fwdBE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic [31:0] writeDataE;
  logic [31:0] aluOutE;
  logic [4:0]  writeRegE;

  logic [31:0] readDataM;
  logic [31:0] resultW;

  logic lwStall;
  logic branchStall;

  // ---------------- IF ----------------
  assign PCPlus4F = pcF + 32'd4;

  always_comb begin
    instrF = 32'h0;
    unique case (pcF[6:2])
      5'd0:    instrF = 32'h20020005;
      5'd1:    instrF = 32'h2003000C;
      5'd2:    instrF = 32'h00432020;
      5'd3:    instrF = 32'hAC040044;
      5'd4:    instrF = 32'h8C050044;
      5'd5:    instrF = 32'h00A23022;
      5'd6:    instrF = 32'h10C30002;
      5'd7:    instrF = 32'h20020063;
      5'd8:    instrF = 32'h20030063;
      5'd9:    instrF = 32'h20420009;
      5'd10:   instrF = 32'h20630001;
      5'd11:   instrF = 32'h00602025;
      5'd12:   instrF = 32'h20850002;
      5'd13:   instrF = 32'h20070041;
      5'd14:   instrF = 32'h00E53820;
      5'd15:   instrF = 32'h1000FFFF;
      default: instrF = 32'h0;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pcF <= '0;
    end else if (!StallF) begin
      pcF <= PCSrcD ? PCBranchD : PCPlus4F;
    end
  end

  // A taken branch squashes the fetched slot unless ID is held.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ifId <= '0;
    end else if (!StallD) begin
      if (PCSrcD) begin
        ifId <= '0;
      end else begin
        ifId <= '{instr: instrF, pcPlus4: PCPlus4F};
      end
    end
  end

  // ---------------- ID ----------------
  assign InstrD   = ifId.instr;
  assign opD      = InstrD[31:26];
  assign rsD      = InstrD[25:21];
  assign rtD      = InstrD[20:16];
  assign rdD      = InstrD[15:11];
  assign functD   = InstrD[5:0];
  assign signImmD = {{16{InstrD[15]}}, InstrD[15:0]};

  always_comb begin
    ctrlD       = '0;
    ctrlD.aluOp = ALU_ADD;
    BranchD     = 1'b0;
    unique case (1'b1)
      (opD == 6'h00): begin
        ctrlD.regDst   = 1'b1;
        ctrlD.regWrite = 1'b1;
        unique case (functD)
          6'h20:   ctrlD.aluOp = ALU_ADD;
          6'h22:   ctrlD.aluOp = ALU_SUB;
          6'h24:   ctrlD.aluOp = ALU_AND;
          6'h25:   ctrlD.aluOp = ALU_OR;
          6'h2A:   ctrlD.aluOp = ALU_SLT;
          default: ctrlD.regWrite = 1'b0;
        endcase
      end
      (opD == 6'h23): begin
        ctrlD.regWrite = 1'b1;
        ctrlD.memtoReg = 1'b1;
        ctrlD.aluSrc   = 1'b1;
      end
      (opD == 6'h2B): begin
        ctrlD.memWrite = 1'b1;
        ctrlD.aluSrc   = 1'b1;
      end
      (opD == 6'h08): begin
        ctrlD.regWrite = 1'b1;
        ctrlD.aluSrc   = 1'b1;
      end
      (opD == 6'h04): BranchD = 1'b1;
      default: ;
    endcase
  end

  // Written on the falling edge so ID reads the WB value same cycle.
  always_ff @(negedge CLK or negedge reset) begin
    if (!reset) begin
      rf <= '{default: '0};
    end else if (memWb.regWrite && memWb.writeReg != 5'd0) begin
      rf[memWb.writeReg] <= resultW;
    end
  end

  assign rd1D = rf[rsD];
  assign rd2D = rf[rtD];

  assign ForwardAD = (rsD != 5'd0) && (rsD == exMem.writeReg)
                  && exMem.regWrite;
  assign ForwardBD = (rtD != 5'd0) && (rtD == exMem.writeReg)
                  && exMem.regWrite;

  assign SrcAD     = ForwardAD ? exMem.aluOut : rd1D;
  assign SrcBD     = ForwardBD ? exMem.aluOut : rd2D;
  assign PCBranchD = {signImmD[29:0], 2'b00} + ifId.pcPlus4;
  assign PCSrcD    = BranchD && (SrcAD == SrcBD);

  // ---------------- hazards ----------------
  assign lwStall = idEx.ctrl.memtoReg
                && (idEx.rt == rsD || idEx.rt == rtD);

  assign branchStall = BranchD && (
      (idEx.ctrl.regWrite
        && (writeRegE == rsD || writeRegE == rtD))
   || (exMem.memtoReg
        && (exMem.writeReg == rsD || exMem.writeReg == rtD)));

  assign StallF = lwStall | branchStall;
  assign StallD = StallF;
  assign FlushE = StallF;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      idEx <= '0;
    end else if (FlushE) begin
      idEx <= '0;
    end else begin
      idEx <= '{ctrl: ctrlD, rs: rsD, rt: rtD, rd: rdD,
                rd1: rd1D, rd2: rd2D, signImm: signImmD};
    end
  end

  // ---------------- EX ----------------
  function automatic logic [1:0] fwdSel(
    input logic [4:0] src,
    input ex_mem_t    m,
    input mem_wb_t    w
  );
    if (m.regWrite && m.writeReg != 5'd0 && m.writeReg == src)
      return 2'b10;
    if (w.regWrite && w.writeReg != 5'd0 && w.writeReg == src)
      return 2'b01;
    return 2'b00;
  endfunction

  assign fwdAE = fwdSel(idEx.rs, exMem, memWb);
  assign fwdBE = fwdSel(idEx.rt, exMem, memWb);

  always_comb begin
    srcAE = idEx.rd1;
    unique case (fwdAE)
      2'b10:   srcAE = exMem.aluOut;
      2'b01:   srcAE = resultW;
      default: srcAE = idEx.rd1;
    endcase
  end

  always_comb begin
    writeDataE = idEx.rd2;
    unique case (fwdBE)
      2'b10:   writeDataE = exMem.aluOut;
      2'b01:   writeDataE = resultW;
      default: writeDataE = idEx.rd2;
    endcase
  end

  assign srcBE     = idEx.ctrl.aluSrc ? idEx.signImm : writeDataE;
  assign writeRegE = idEx.ctrl.regDst ? idEx.rd : idEx.rt;

  always_comb begin
    aluOutE = '0;
    unique case (idEx.ctrl.aluOp)
      ALU_AND: aluOutE = srcAE & srcBE;
      ALU_OR:  aluOutE = srcAE | srcBE;
      ALU_ADD: aluOutE = srcAE + srcBE;
      ALU_SUB: aluOutE = srcAE - srcBE;
      ALU_SLT: aluOutE = {31'd0, $signed(srcAE) < $signed(srcBE)};
      default: aluOutE = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      exMem <= '0;
    end else begin
      exMem <= '{regWrite: idEx.ctrl.regWrite,
                 memtoReg: idEx.ctrl.memtoReg,
                 memWrite: idEx.ctrl.memWrite,
                 aluOut: aluOutE,
                 writeData: writeDataE,
                 writeReg: writeRegE};
    end
  end

  // ---------------- MEM ----------------
  assign readDataM = dmem[exMem.aluOut[7:2]];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      dmem <= '{default: '0};
    end else if (exMem.memWrite) begin
      dmem[exMem.aluOut[7:2]] <= exMem.writeData;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      memWb <= '0;
    end else begin
      memWb <= '{regWrite: exMem.regWrite,
                 memtoReg: exMem.memtoReg,
                 aluOut: exMem.aluOut,
                 readData: readDataM,
                 writeReg: exMem.writeReg};
    end
  end

  // ---------------- WB ----------------
  assign resultW = memWb.memtoReg ? memWb.readData : memWb.aluOut;

  assign out[0] = rf[2];
  assign out[1] = rf[3];
  assign out[2] = rf[4];
  assign out[3] = rf[5];
  assign out[4] = rf[7];

endmodule

// File: tb/tb_mips_datapath.sv
// Scoreboard bench: an ISA-level interpreter predicts the visible
// register-write sequence; a monitor checks it plus hazard behaviour.
module tb_mips_datapath;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] out [4:0];
  logic [31:0] InstrD, PCPlus4F, PCBranchD, SrcAD, SrcBD;
  logic        StallF, StallD, FlushE;
  logic        ForwardAD, ForwardBD, BranchD, PCSrcD;

  mips_datapath dut (
    .CLK(CLK), .reset(reset), .out(out),
    .InstrD(InstrD), .PCPlus4F(PCPlus4F),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .BranchD(BranchD), .PCSrcD(PCSrcD),
    .PCBranchD(PCBranchD), .SrcAD(SrcAD), .SrcBD(SrcBD)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] PROG [16] = '{
    32'h20020005, 32'h2003000C, 32'h00432020, 32'hAC040044,
    32'h8C050044, 32'h00A23022, 32'h10C30002, 32'h20020063,
    32'h20030063, 32'h20420009, 32'h20630001, 32'h00602025,
    32'h20850002, 32'h20070041, 32'h00E53820, 32'h1000FFFF};
  localparam logic [31:0] SUB_I  = 32'h00A23022;
  localparam logic [31:0] BEQ_I  = 32'h10C30002;
  localparam logic [31:0] SPIN_I = 32'h1000FFFF;
  localparam int VIS [5] = '{2, 3, 4, 5, 7};

  typedef struct {
    int          idx;
    logic [31:0] val;
  } ev_t;

  ev_t         expQ [$];
  logic [31:0] expFinal [5];
  int          errors = 0;
  int          checks = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h",
               name, act, exp);
    end
  endtask

  task automatic checkTrue(string name, bit ok, int act);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d outside required bound", name, act);
    end
  endtask

  function automatic int visIdx(int r);
    for (int k = 0; k < 5; k++) if (VIS[k] == r) return k;
    return -1;
  endfunction

  // Architectural interpreter of the program; no pipeline notion.
  function automatic void buildExpect();
    logic [31:0] r [32];
    logic [31:0] m [64];
    int pc;
    r  = '{default: '0};
    m  = '{default: '0};
    pc = 0;
    expQ.delete();
    for (int step = 0; step < 200; step++) begin
      logic [31:0] ins, imm, v;
      int op, rs, rt, rd, fn, dst, a;
      bit wr;
      ins = (pc / 4 < 16) ? PROG[pc / 4] : 32'h0;
      if (ins == SPIN_I) break;
      op  = int'(ins[31:26]);
      rs  = int'(ins[25:21]);
      rt  = int'(ins[20:16]);
      rd  = int'(ins[15:11]);
      fn  = int'(ins[5:0]);
      imm = {{16{ins[15]}}, ins[15:0]};
      a   = int'(((r[rs] + imm) >> 2) & 32'h3F);
      wr  = 1'b0;
      dst = 0;
      v   = '0;
      pc += 4;
      case (op)
        'h00: begin
          dst = rd;
          wr  = 1'b1;
          case (fn)
            'h20: v = r[rs] + r[rt];
            'h22: v = r[rs] - r[rt];
            'h24: v = r[rs] & r[rt];
            'h25: v = r[rs] | r[rt];
            'h2A: v = ($signed(r[rs]) < $signed(r[rt])) ? 1 : 0;
            default: wr = 1'b0;
          endcase
        end
        'h08: begin dst = rt; v = r[rs] + imm; wr = 1'b1; end
        'h23: begin dst = rt; v = m[a]; wr = 1'b1; end
        'h2B: m[a] = r[rt];
        'h04: if (r[rs] == r[rt]) pc += 4 * int'($signed(imm));
        default: ;
      endcase
      if (wr && dst != 0) begin
        if (visIdx(dst) >= 0 && r[dst] != v)
          expQ.push_back('{visIdx(dst), v});
        r[dst] = v;
      end
    end
    for (int k = 0; k < 5; k++) expFinal[k] = r[VIS[k]];
  endfunction

  logic [31:0] prevOut [5];
  int  cyc, stallRun, luStalls, brStalls, spinCyc;
  bit  brChecked;

  always @(posedge CLK) begin
    #1;
    if (!reset) begin
      for (int k = 0; k < 5; k++) prevOut[k] = out[k];
      cyc = 0; stallRun = 0; luStalls = 0; brStalls = 0;
      spinCyc = -1; brChecked = 1'b0;
    end else begin
      cyc++;
      for (int k = 0; k < 5; k++) begin
        if (out[k] !== prevOut[k]) begin
          if (expQ.size() == 0) begin
            checkTrue("unexpected_write", 1'b0, k);
          end else begin
            ev_t e;
            e = expQ.pop_front();
            check("write_reg", k, e.idx);
            check("write_val", out[k], e.val);
          end
          prevOut[k] = out[k];
        end
      end
      check("stallD_eq_stallF", StallD, StallF);
      check("flushE_eq_stallF", FlushE, StallF);
      stallRun = StallF ? stallRun + 1 : 0;
      checkTrue("stall_run", stallRun <= 2, stallRun);
      checkTrue("pcplus4_bound", PCPlus4F <= 32'h44, PCPlus4F);
      if (InstrD == SUB_I && StallD) luStalls++;
      if (InstrD == BEQ_I && StallD) brStalls++;
      if (InstrD == BEQ_I && !StallD) begin
        check("beq_fwdA", ForwardAD, 1'b1);
        check("beq_srcA", SrcAD, 32'd12);
        check("beq_srcB", SrcBD, 32'd12);
        check("beq_taken", PCSrcD, 1'b1);
        check("beq_target", PCBranchD, 32'd36);
        brChecked = 1'b1;
      end
      if (InstrD == SPIN_I) begin
        if (spinCyc < 0) spinCyc = cyc;
        check("spin_branch", BranchD, 1'b1);
        check("spin_taken", PCSrcD, 1'b1);
        check("spin_target", PCBranchD, 32'd60);
        check("spin_nostall", StallD, 1'b0);
      end
    end
  end

  task automatic checkResetState();
    for (int k = 0; k < 5; k++) check("rst_out", out[k], 32'd0);
    check("rst_pcplus4", PCPlus4F, 32'd4);
    check("rst_instrD", InstrD, 32'd0);
    check("rst_stallF", StallF, 1'b0);
    check("rst_stallD", StallD, 1'b0);
    check("rst_flushE", FlushE, 1'b0);
    check("rst_pcsrc", PCSrcD, 1'b0);
    check("rst_fwdA", ForwardAD, 1'b0);
    check("rst_fwdB", ForwardBD, 1'b0);
  endtask

  task automatic doReset(int n);
    @(posedge CLK);
    #3 reset = 1'b0;
    #1 checkResetState();
    repeat (n) @(posedge CLK);
    #3 checkResetState();
    buildExpect();
    reset = 1'b1;
  endtask

  task automatic runFull();
    repeat (100) @(posedge CLK);
    #3;
    check("queue_drained", expQ.size(), 0);
    for (int k = 0; k < 5; k++) check("final_out", out[k], expFinal[k]);
    check("loaduse_stalls", luStalls, 1);
    check("branch_stalls", brStalls, 1);
    check("branch_seen", brChecked, 1'b1);
    checkTrue("spin_by_25", spinCyc >= 1 && spinCyc <= 25, spinCyc);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #3 checkResetState();
    buildExpect();
    check("model_rf2", expFinal[0], 32'd14);
    check("model_rf7", expFinal[4], 32'd80);
    reset = 1'b1;
    runFull();
    doReset(1);
    repeat (30) @(posedge CLK);
    doReset(1);
    runFull();
    for (int it = 0; it < 4; it++) begin
      doReset(int'($urandom_range(1, 3)));
      repeat (int'($urandom_range(2, 40))) @(posedge CLK);
      doReset(int'($urandom_range(1, 3)));
      runFull();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
